// File: rtl/nfs_pkg.sv
// nfs_pkg: shared types and constants for normalize_float64_sig.
//   state_t     FSM encoding (IDLE/SHIFT/DONE)
//   SIG_W/EXP_W significand and exponent widths (fixed at 64/13)
//   CNT_W       width of the accumulated shift count (max 63)
//   STEP_SIZES  shift amounts visited by the SHIFT phase, largest first
//   step_idx_t  index into STEP_SIZES
package nfs_pkg;

   localparam int SIG_W     = 64;
   localparam int EXP_W     = 13;
   localparam int CNT_W     = 7;
   localparam int NUM_STEPS = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef logic [2:0] step_idx_t;

   localparam logic [5:0] STEP_SIZES [NUM_STEPS] = '{6'd32, 6'd16, 6'd8, 6'd4, 6'd2, 6'd1};

   // Out-of-range indices fall back to the smallest step.
   function automatic logic [5:0] step_size(step_idx_t idx);
      step_size = 6'd1;
      for (int i = 0; i < NUM_STEPS; i++) begin
         if (idx == step_idx_t'(i)) step_size = STEP_SIZES[i];
      end
   endfunction

endpackage

// File: rtl/nfs_shift_step.sv
// nfs_shift_step: one conditional left-shift stage of the normaliser.
//   sig_in/cnt_in   significand and running shift count
//   k               shift amount for this stage (1..32)
//   sig_out/cnt_out shifted significand and updated count
// The stage shifts by k only when bits [62 -: k] are all zero, so the
// MSB can never move past bit 62.
module nfs_shift_step
   import nfs_pkg::*;
(
   input  logic [SIG_W-1:0] sig_in,
   input  logic [CNT_W-1:0] cnt_in,
   input  logic [5:0]       k,
   output logic [SIG_W-1:0] sig_out,
   output logic [CNT_W-1:0] cnt_out
);

   logic [SIG_W-1:0] top_bits;
   logic             top_zero;

   always_comb begin
      // Bit 63 is masked; right-shifting by 63-k leaves exactly bits [62 -: k].
      top_bits = {1'b0, sig_in[SIG_W-2:0]} >> (6'd63 - k);
      top_zero = (top_bits == '0);
      sig_out  = top_zero ? (sig_in << k) : sig_in;
      cnt_out  = top_zero ? (cnt_in + {1'b0, k}) : cnt_in;
   end

endmodule

// File: rtl/normalize_float64_sig.sv
// normalize_float64_sig: front half of normalizeRoundAndPackFloat64.
// Shifts an unnormalised significand so its MSB sits at bit 62 and
// adjusts the exponent (modulo 2^13) by the shift amount. A set input
// bit 63 is handled by a one-place right shift with sticky jam into bit 0.
// Ports:
//   ap_clk, ap_rst_n (async, active-low)
//   ap_start/ap_done/ap_idle/ap_ready  ap_ctrl_hs style handshake:
//     a request is accepted on a rising edge where ap_start=1 in IDLE;
//     ap_done and ap_ready pulse together for the single DONE cycle.
//   zSign/zExp/zSig        request operands, sampled on accept
//   norm_sign/norm_exp/norm_sig/norm_jam  registered result, held until
//                          the next DONE
//   dbg_state              current FSM state
// Build option: define NORM_FAST_CLZ_EN to evaluate all six shift steps in
// a single SHIFT cycle (latency 2) instead of one step per cycle (latency 7).
module normalize_float64_sig
   import nfs_pkg::*;
(
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             ap_start,
   output logic             ap_done,
   output logic             ap_idle,
   output logic             ap_ready,
   input  logic             zSign,
   input  logic [12:0]      zExp,
   input  logic [63:0]      zSig,
   output logic             norm_sign,
   output logic [12:0]      norm_exp,
   output logic [63:0]      norm_sig,
   output logic             norm_jam,
   output logic [1:0]       dbg_state
);

   state_t           state_q, state_d;
   logic [SIG_W-1:0] work_sig_q, work_sig_d;
   logic [EXP_W-1:0] work_exp_q, work_exp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sign_q, sign_d;
   logic             jam_q, jam_d;
   logic [SIG_W-1:0] norm_sig_q, norm_sig_d;
   logic [EXP_W-1:0] norm_exp_q, norm_exp_d;
   logic             norm_sign_q, norm_sign_d;
   logic             norm_jam_q, norm_jam_d;

   // Result of the shift work done in the current SHIFT cycle.
   logic [SIG_W-1:0] fin_sig;
   logic [CNT_W-1:0] fin_cnt;
   logic             last_step;

`ifdef NORM_FAST_CLZ_EN
   logic [SIG_W-1:0] chain_sig [NUM_STEPS+1];
   logic [CNT_W-1:0] chain_cnt [NUM_STEPS+1];

   assign chain_sig[0] = work_sig_q;
   assign chain_cnt[0] = cnt_q;

   for (genvar g = 0; g < NUM_STEPS; g++) begin : g_chain
      nfs_shift_step u_step (
         .sig_in  (chain_sig[g]),
         .cnt_in  (chain_cnt[g]),
         .k       (STEP_SIZES[g]),
         .sig_out (chain_sig[g+1]),
         .cnt_out (chain_cnt[g+1])
      );
   end

   assign fin_sig   = chain_sig[NUM_STEPS];
   assign fin_cnt   = chain_cnt[NUM_STEPS];
   assign last_step = 1'b1;
`else
   step_idx_t step_q, step_d;

   nfs_shift_step u_step (
      .sig_in  (work_sig_q),
      .cnt_in  (cnt_q),
      .k       (step_size(step_q)),
      .sig_out (fin_sig),
      .cnt_out (fin_cnt)
   );

   assign last_step = (step_q == step_idx_t'(NUM_STEPS - 1));

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) step_q <= '0;
      else           step_q <= step_d;
   end
`endif

   // State and datapath registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= IDLE;
         work_sig_q  <= '0;
         work_exp_q  <= '0;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         jam_q       <= 1'b0;
         norm_sig_q  <= '0;
         norm_exp_q  <= '0;
         norm_sign_q <= 1'b0;
         norm_jam_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_sig_q  <= work_sig_d;
         work_exp_q  <= work_exp_d;
         cnt_q       <= cnt_d;
         sign_q      <= sign_d;
         jam_q       <= jam_d;
         norm_sig_q  <= norm_sig_d;
         norm_exp_q  <= norm_exp_d;
         norm_sign_q <= norm_sign_d;
         norm_jam_q  <= norm_jam_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      work_sig_d  = work_sig_q;
      work_exp_d  = work_exp_q;
      cnt_d       = cnt_q;
      sign_d      = sign_q;
      jam_d       = jam_q;
      norm_sig_d  = norm_sig_q;
      norm_exp_d  = norm_exp_q;
      norm_sign_d = norm_sign_q;
      norm_jam_d  = norm_jam_q;
`ifndef NORM_FAST_CLZ_EN
      step_d      = step_q;
`endif
      case (state_q)
         IDLE: begin
            if (ap_start) begin
               sign_d = zSign;
               cnt_d  = '0;
`ifndef NORM_FAST_CLZ_EN
               step_d = '0;
`endif
               if (zSig[63]) begin
                  // Right shift by one; the dropped bit is jammed into bit 0.
                  work_sig_d = {1'b0, zSig[63:1]} | {63'b0, zSig[0]};
                  work_exp_d = zExp + 13'd1;
                  jam_d      = 1'b1;
               end else begin
                  work_sig_d = zSig;
                  work_exp_d = zExp;
                  jam_d      = 1'b0;
               end
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            work_sig_d = fin_sig;
            cnt_d      = fin_cnt;
`ifndef NORM_FAST_CLZ_EN
            step_d     = step_q + 3'd1;
`endif
            if (last_step) begin
               norm_sig_d  = fin_sig;
               norm_exp_d  = work_exp_q - {{(EXP_W-CNT_W){1'b0}}, fin_cnt};
               norm_sign_d = sign_q;
               norm_jam_d  = jam_q;
               state_d     = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs.
   always_comb begin
      ap_idle   = (state_q == IDLE);
      ap_done   = (state_q == DONE);
      ap_ready  = (state_q == DONE);
      norm_sig  = norm_sig_q;
      norm_exp  = norm_exp_q;
      norm_sign = norm_sign_q;
      norm_jam  = norm_jam_q;
      dbg_state = state_q;
   end

endmodule

// File: doc/normalize_float64_sig.md
Name: normalize_float64_sig

Overview:
- Upstream normalisation stage for the float64 round-and-pack unit.
- Takes an unnormalised sign/exponent/significand triple and shifts the significand so its MSB lands at bit 62, adjusting the exponent to match.
- Implements the front half of normalizeRoundAndPackFloat64.
- Output triple connects directly to the round-and-pack stage's zSign/zExp/zSig inputs; start/done handshake matches that stage's ap_ctrl_hs style.

Parameters:
- SIG_W, 64, significand width (fixed; other values unsupported)
- EXP_W, 13, exponent width, two's complement

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  reset
- ap_start  in  1  request; inputs sampled when accepted
- ap_done  out  1  one-cycle pulse, result valid
- ap_idle  out  1  high in IDLE only
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- zSign  in  1  sign
- zExp  in  13  exponent, two's complement
- zSig  in  64  unnormalised significand
- norm_sign  out  1  registered sign
- norm_exp  out  13  adjusted exponent
- norm_sig  out  64  normalised significand
- norm_jam  out  1  set when a right-jam was applied (input bit 63 set)

Behaviour:
- Interface (already decided): one clock, ap_clk; reset ap_rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except ap_idle=1. State = IDLE. Internal sig/exp/count registers = 0.
- Reset mid-operation: immediate clear; no ap_done is issued for the aborted request.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - ap_idle=1.
  - If ap_start=1 at cycle T, capture zSign/zExp/zSig at the edge ending T, with count=0.
  - If zSig[63]=1: captured sig = {1'b0, zSig[63:1]} with bit0 |= zSig[0] (jam), exp = zExp+1, jam flag set.
  - Go to SHIFT.
- SHIFT:
  - Step k in {32,16,8,4,2,1}, one step per cycle (cycles T+1..T+6).
  - If sig[62 -: k]==0: sig <<= k, count += k.
  - After the k=1 step, go to DONE.
  - Steps are still executed after a jam; all of them find a non-zero top and do nothing.
- DONE (cycle T+7):
  - Output registers are loaded at entry and are valid throughout T+7.
  - ap_done=ap_ready=1 for exactly this cycle.
  - Unconditionally return to IDLE.
- Latency: 7 cycles from accept to ap_done; throughput one request per 8 cycles.
- Outputs hold their values until the next DONE entry.
- Exponent: norm_exp = zExp - count (or zExp+1 on jam), computed modulo 2^13. No saturation and no flags; overflow/underflow is the downstream stage's job.
- zSig==0: all steps shift, count=63, norm_sig=0, norm_exp=zExp-63.
- ap_start outside IDLE (SHIFT or DONE) is ignored and not queued. The requester must hold ap_start until ap_ready.
- Input changes during SHIFT have no effect.

Optional Feature:
- NORM_FAST_CLZ_EN defined: all six shift steps are evaluated combinationally in a single SHIFT cycle. DONE is at T+2; latency 2, throughput one per 3 cycles. Results are bit-identical to the iterative mode.
- Undefined: iterative 6-cycle SHIFT as above.

Decomposition:
- Package nfs_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - SIG_W/EXP_W localparams
  - step-size constant array {32,16,8,4,2,1}
  - 3-bit step index type
- Sub-module nfs_shift_step: one conditional shift stage (sig, count, k) -> (sig', count'). Instanced once and driven by the step index in iterative mode; chained six times under NORM_FAST_CLZ_EN.

Test Plan:
- zSig=0x0000000000000001, zExp=0x0400, start at T -> T+7: norm_sig=0x4000000000000000, norm_exp=0x03C2, jam=0, ap_done pulse one cycle.
- zSig=0x8000000000000001, zExp=0x03FF -> norm_sig=0x4000000000000001, norm_exp=0x0400, jam=1.
- zSig=0, zExp=0x0010 -> norm_sig=0, norm_exp=0x1FD1.
- zSig=0x0000000000000100, zExp=0x0005 -> norm_sig=0x4000000000000000, norm_exp=0x1FCF. zSig=0x4000000000000000 -> unchanged, exp unchanged.
- ap_start held high continuously -> accepts only in IDLE; ap_done at T+7, T+15, ... Inputs changed during SHIFT are ignored.
- ap_rst_n pulled low at T+3 -> outputs 0 and ap_idle=1 immediately, no ap_done. After release, a new request completes normally. Repeat the first scenario with NORM_FAST_CLZ_EN defined -> same values at T+2.
